// File: rtl/dmem_responder_if.sv
// Request/response bus between a memory initiator and dmem_responder.
// master: initiator side (drives req_*, rsp_ready).
// slave : responder side (drives req_ready, rsp_*).
interface dmem_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_write;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_write, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_write, rsp_rdata
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// A request is accepted in IDLE, waits LATENCY edges in BUSY, commits the
// load/store and presents the response in RESP until rsp_ready.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset (storage contents are kept)
//   bus     - dmem_if slave modport: req_valid/ready/write/addr/wdata,
//             rsp_valid/ready/write/rdata
// LATENCY legal range is 1..15 (4-bit wait counter).
module dmem_responder #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned LATENCY = 2
) (
   input logic   clk,
   input logic   reset_n,
   dmem_if.slave bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              commit_c;

   logic [DATA_W-1:0] mem_q [DEPTH];

   // State and latched request/response registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Next-state and response datapath
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      commit_c    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               wr_d    = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Load data is the pre-commit storage value; stores echo wdata
               commit_c    = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_write_d = wr_q;
               rsp_rdata_d = wr_q ? wdata_q : mem_q[addr_q];
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Storage is not reset; reset forces IDLE so no commit can fire during it
   always_ff @(posedge clk) begin
      if (commit_c && wr_q) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_write = rsp_write_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed latency/stall/reset scenarios,
// throughput on LATENCY=1 and LATENCY=15 instances, then random traffic with
// random response back-pressure against a reference memory.
module tb_dmem_responder;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;
   localparam int          LAT    = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic rst_t_n = 1'b0;

   always #5 clk = ~clk;

   dmem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   dmem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifa ();
   dmem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifb ();

   dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );
   dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset_n(rst_t_n), .bus(ifa)
   );
   dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(15)) dut_l15 (
      .clk(clk), .reset_n(rst_t_n), .bus(ifb)
   );

   typedef struct {
      logic              wr;
      logic [DATA_W-1:0] data;
      logic              chk;
      int                acc;
   } exp_t;

   exp_t              exp_q[$];
   exp_t              mon_e;
   logic [DATA_W-1:0] ref_mem [256];
   logic              known   [256];

   int   checks  = 0;
   int   failures = 0;
   int   cyc     = 0;
   int   n_push  = 0;
   int   n_pop   = 0;
   int   n_abort = 0;
   bit   rr_mode = 1'b0;
   logic rr_fixed = 1'b1;
   bit   outstanding = 1'b0;
   logic              prev_v = 1'b0;
   logic              prev_w = 1'b0;
   logic [DATA_W-1:0] prev_d = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: got no event expected one (t=%0t)", name, $time);
   endtask

   // Response back-pressure: random or fixed, changed just after each edge
   always @(posedge clk) begin
      #1;
      bus.rsp_ready = rr_mode ? 1'($urandom_range(0, 1)) : rr_fixed;
   end

   // Monitor: pops the scoreboard on each response handshake
   always @(negedge clk) begin
      if (!reset_n) begin
         outstanding = 1'b0;
         prev_v      = 1'b0;
      end else begin
         check("req_ready", 32'(bus.req_ready), 32'(!outstanding));
         if (bus.rsp_valid && !prev_v) begin
            if (exp_q.size() == 0) fail_now("rsp_unexpected");
            else check("latency", 32'(cyc - exp_q[0].acc), 32'(LAT));
         end
         if (bus.rsp_valid && prev_v) begin
            check("hold_rdata", 32'(bus.rsp_rdata), 32'(prev_d));
            check("hold_write", 32'(bus.rsp_write), 32'(prev_w));
         end
         if (bus.rsp_valid && bus.rsp_ready && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_pop++;
            check("rsp_write", 32'(bus.rsp_write), 32'(mon_e.wr));
            if (mon_e.chk) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_e.data));
            outstanding = 1'b0;
         end
         if (bus.req_valid && bus.req_ready) outstanding = 1'b1;
         prev_v = bus.rsp_valid;
         prev_w = bus.rsp_write;
         prev_d = bus.rsp_rdata;
      end
   end

   // Present a request until accepted; push the model's expected response
   task automatic issue(input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit sync, output int waited);
      exp_t e;
      if (sync) begin
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      waited = 0;
      forever begin
         @(negedge clk);
         if (reset_n && bus.req_ready) break;
         waited++;
         if (waited > 200) break;
      end
      if (waited > 200) begin
         fail_now("accept_timeout");
      end else begin
         e.wr  = wr;
         e.acc = cyc + 1;
         if (wr) begin
            e.data = d;
            e.chk  = 1'b1;
            ref_mem[a] = d;
            known[a]   = 1'b1;
         end else begin
            e.data = ref_mem[a];
            e.chk  = known[a];
         end
         exp_q.push_back(e);
         n_push++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = ADDR_W'($urandom);
      bus.req_wdata = DATA_W'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) fail_now("idle_timeout");
   endtask

   task automatic wait_rsp();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rsp_valid && n < 100);
      if (!bus.rsp_valid) fail_now("rsp_timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int last_a, last_b, na, nb;
      logic [DATA_W-1:0] saved_d;
      logic              saved_k;

      for (int i = 0; i < 256; i++) begin
         known[i]   = 1'b0;
         ref_mem[i] = '0;
      end
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
      ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
      ifa.rsp_ready = 1'b1;
      ifb.rsp_ready = 1'b1;

      // Reset values
      #1;
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_write", 32'(bus.rsp_write), 0);
      check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
      check("rst_req_ready", 32'(bus.req_ready), 1);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      rst_t_n = 1'b1;

      // Throughput with continuous requests and rsp_ready=1
      ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 8'h01; ifa.req_wdata = 16'h0A11;
      ifb.req_valid = 1'b1; ifb.req_write = 1'b1; ifb.req_addr = 8'h02; ifb.req_wdata = 16'h0B22;
      last_a = -1; last_b = -1; na = 0; nb = 0;
      repeat (90) begin
         @(negedge clk);
         if (ifa.rsp_valid) begin
            check("l1_latency", 32'(cyc - last_a), 1);
            check("l1_rdata", 32'(ifa.rsp_rdata), 32'h0A11);
         end
         if (ifa.req_valid && ifa.req_ready) begin
            if (last_a >= 0) check("l1_spacing", 32'(cyc + 1 - last_a), 3);
            last_a = cyc + 1;
            na++;
         end
         if (ifb.rsp_valid) begin
            check("l15_latency", 32'(cyc - last_b), 15);
            check("l15_rdata", 32'(ifb.rsp_rdata), 32'h0B22);
         end
         if (ifb.req_valid && ifb.req_ready) begin
            if (last_b >= 0) check("l15_spacing", 32'(cyc + 1 - last_b), 17);
            last_b = cyc + 1;
            nb++;
         end
      end
      ifa.req_valid = 1'b0;
      ifb.req_valid = 1'b0;
      check("l1_count_ok", 32'(na >= 25), 1);
      check("l15_count_ok", 32'(nb >= 5), 1);

      // Store then load of the same word
      rr_fixed = 1'b1;
      issue(1'b1, 8'h10, 16'hBEEF, 1'b1, w);
      wait_idle();
      issue(1'b0, 8'h10, 16'h0000, 1'b1, w);
      wait_idle();

      // Stall in RESP while a new request waits
      rr_fixed = 1'b0;
      issue(1'b1, 8'h20, 16'hA5A5, 1'b1, w);
      wait_rsp();
      fork
         issue(1'b0, 8'h20, 16'h0000, 1'b1, w);
         begin
            repeat (5) @(negedge clk);
            rr_fixed = 1'b1;
         end
      join
      check("stall_req_ignored", 32'(w >= 5), 1);
      wait_idle();

      // Reset mid-BUSY aborts a store
      issue(1'b1, 8'hFF, 16'h1234, 1'b1, w);
      wait_idle();
      saved_d = ref_mem[8'hFF];
      saved_k = known[8'hFF];
      issue(1'b1, 8'hFF, 16'h5555, 1'b1, w);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_rsp_valid", 32'(bus.rsp_valid), 0);
      check("abort_rsp_write", 32'(bus.rsp_write), 0);
      check("abort_rsp_rdata", 32'(bus.rsp_rdata), 0);
      check("abort_req_ready", 32'(bus.req_ready), 1);
      ref_mem[8'hFF] = saved_d;
      known[8'hFF]   = saved_k;
      exp_q.delete();
      n_abort++;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      issue(1'b0, 8'hFF, 16'h0000, 1'b1, w);
      wait_idle();

      // Reset during RESP drops rsp_valid without a clock edge
      rr_fixed = 1'b0;
      issue(1'b1, 8'h30, 16'h7777, 1'b1, w);
      wait_rsp();
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("resp_rst_valid", 32'(bus.rsp_valid), 0);
      check("resp_rst_rdata", 32'(bus.rsp_rdata), 0);
      check("resp_rst_ready", 32'(bus.req_ready), 1);
      exp_q.delete();
      n_abort++;
      rr_fixed = 1'b1;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      issue(1'b0, 8'h30, 16'h0000, 1'b0, w);
      check("post_reset_accept_wait", 32'(w), 0);
      wait_idle();

      // Random traffic with random back-pressure
      rr_mode = 1'b1;
      for (int i = 0; i < 200; i++) begin
         logic              r_wr;
         logic [ADDR_W-1:0] r_a;
         logic [DATA_W-1:0] r_d;
         r_wr = 1'($urandom_range(0, 1));
         r_a  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
         r_d  = DATA_W'($urandom);
         issue(r_wr, r_a, r_d, 1'b1, w);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      wait_idle();
      rr_mode = 1'b0;
      repeat (3) @(posedge clk);

      check("queue_empty", 32'(exp_q.size()), 0);
      check("rsp_count", 32'(n_pop), 32'(n_push - n_abort));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, address width; storage depth SHALL be 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter LATENCY, default 2, legal range 1..15, cycles from request acceptance edge to rsp_valid rise.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset; assertion SHALL take effect immediately, independent of clk.
REQ-006 req_valid  in  1  initiator presents a memory request.
REQ-007 req_ready  out  1  responder can accept a request this cycle.
REQ-008 req_write  in  1  1 = store, 0 = load; sampled at acceptance.
REQ-009 req_addr  in  ADDR_W  word address; sampled at acceptance.
REQ-010 req_wdata  in  DATA_W  store data; sampled at acceptance.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  initiator consumes the response.
REQ-013 rsp_write  out  1  echo of req_write for the current response.
REQ-014 rsp_rdata  out  DATA_W  load data; for stores, equals the data written.

Function
REQ-015 FSM states SHALL be IDLE, BUSY and RESP, with exactly one request outstanding at any time.
REQ-016 req_ready SHALL be 1 only in IDLE, decoded from state, with no dependence on req_valid.
REQ-017 Acceptance SHALL occur on a rising edge where state=IDLE, req_valid=1 and reset_n=1; write, addr and wdata SHALL be latched, a 4-bit counter loaded with LATENCY-1, and the state moved to BUSY.
REQ-018 In BUSY with counter!=0, the counter SHALL decrement by 1 per edge; req_* inputs SHALL be ignored.
REQ-019 In BUSY with counter==0, the next edge SHALL commit the operation and enter RESP with rsp_valid=1, so that rsp_valid rises exactly LATENCY edges after the acceptance edge.
REQ-020 Commit for a store: mem[addr]<=wdata, rsp_rdata<=wdata, rsp_write<=1.
REQ-021 Commit for a load: rsp_rdata<=mem[addr] (value before this commit), rsp_write<=0.
REQ-022 In RESP, rsp_valid, rsp_rdata and rsp_write SHALL hold stable until an edge with rsp_ready=1; that edge SHALL clear rsp_valid and return to IDLE.
REQ-023 A load issued after a store to the same address SHALL return the stored data (store commits before the next acceptance is possible).
REQ-024 rsp_ready=1 outside RESP SHALL have no effect.
REQ-025 Back-to-back throughput SHALL be one request per LATENCY+2 cycles minimum (one IDLE bubble after each handshake).
REQ-026 The address SHALL use the full ADDR_W bits with no out-of-range case; the counter SHALL never underflow.
REQ-027 Storage SHALL be a register array written only at store commit; its contents SHALL NOT be cleared by reset.

Reset
REQ-028 While reset_n=0: state=IDLE, counter=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, latched request fields=0.
REQ-029 Reset asserted in BUSY before the commit edge SHALL abort the request; no storage write SHALL occur and no response SHALL be issued.
REQ-030 Reset asserted in RESP SHALL drop rsp_valid immediately (asynchronously), leaving an already-committed store in storage.
REQ-031 The first edge after reset_n rises SHALL be able to accept a request (req_ready=1).

Verification
REQ-032 LATENCY=2: store addr 0x10 data 0xBEEF accepted at edge 0 -> rsp_valid=1 after edge 2, rsp_write=1, rsp_rdata=0xBEEF; load 0x10 -> rsp_rdata=0xBEEF, rsp_write=0.
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable throughout; req_ready=0; the new req_valid is ignored until IDLE.
REQ-034 LATENCY=1 and LATENCY=15, continuous req_valid with rsp_ready=1 -> acceptances spaced 3 and 17 cycles apart; each rsp_valid at acceptance+LATENCY.
REQ-035 Store 0x1234 to 0xFF, then assert reset_n=0 mid-BUSY during a store of 0x5555 to 0xFF -> outputs zero at once; a later load of 0xFF returns 0x1234.
REQ-036 Reset asserted while in RESP -> rsp_valid falls without a clock edge; first post-reset edge with req_valid=1 is accepted.
REQ-037 Random store/load sequence against a reference memory model, random rsp_ready stalls -> every load matches the model, and exactly one response per acceptance.
